serial_subtractor: RTL and testbench

//   Bit-serial subtractor: the inverse-operation companion to the combinational full adder.

---
 rtl/serial_arith_pkg.sv | 21 ++
 rtl/serial_subtractor_fs.sv | 20 ++
 rtl/serial_subtractor.sv | 116 +++++++++++
 tb/tb_serial_subtractor.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// ============================================================
// serial_arith_pkg : shared types and helpers for bit-serial arithmetic
// Rev 1.0
// ============================================================
`default_nettype none

package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ser_state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_fs.sv
// ============================================================
// full_subtractor : one-bit combinational subtractor cell
// Rev 1.0
// ============================================================
`default_nettype none

module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic BIN,
  output logic D,
  output logic BOUT
);

  assign D    = A ^ B ^ BIN;
  assign BOUT = (~A & B) | (~(A ^ B) & BIN);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================
// serial_subtractor : LSB-first bit-serial A - B - BIN with valid/ready
// Rev 1.0
// ============================================================
`default_nettype none

module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] DIFF,
  output logic             BOUT
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  ser_state_t       state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic [WIDTH-1:0] diff_d;
  logic             borrow_q;
  logic             bout_q;
  logic [CW-1:0]    cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             cell_d;
  logic             cell_bout;

  full_subtractor u_cell (
    .A    (a_q[0]),
    .B    (b_q[0]),
    .BIN  (borrow_q),
    .D    (cell_d),
    .BOUT (cell_bout)
  );

  // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_w1
      assign diff_d = cell_d;
    end else begin : g_wn
      assign diff_d = {cell_d, diff_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      bout_q      <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= A;
            b_q        <= B;
            borrow_q   <= BIN;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          diff_q   <= diff_d;
          borrow_q <= cell_bout;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            bout_q      <= cell_bout;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign DIFF      = diff_q;
  assign BOUT      = bout_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================
// tb_serial_subtractor : directed and random checks, WIDTH=8 and WIDTH=1
// Rev 1.0
// ============================================================
`default_nettype none

module tb_serial_subtractor;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  int         cyc   = 0;
  int         checks = 0;
  int         errors = 0;

  logic       iv8 = 1'b0, or8 = 1'b1, bin8 = 1'b0;
  logic [7:0] a8 = 8'h00, b8 = 8'h00;
  logic       ir8, ov8, bout8;
  logic [7:0] d8;

  logic       iv1 = 1'b0, or1 = 1'b1, bin1 = 1'b0;
  logic [0:0] a1 = 1'b0, b1 = 1'b0;
  logic       ir1, ov1, bout1;
  logic [0:0] d1;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
    .BIN(bin8), .out_valid(ov8), .out_ready(or8), .DIFF(d8), .BOUT(bout8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .A(a1), .B(b1),
    .BIN(bin1), .out_valid(ov1), .out_ready(or1), .DIFF(d1), .BOUT(bout1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 operation; optional backpressure and in_valid noise while busy.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                     input int hold, input bit noise, input string tag, output int acc);
    logic [8:0] r;
    int n;
    r = {1'b0, a} - {1'b0, b} - {8'd0, bin};
    n = 0;
    while (ir8 !== 1'b1 && n < 50) begin tick(); n++; end
    chk({tag, "_ready"}, 64'(ir8), 64'd1);
    a8 = a; b8 = b; bin8 = bin; iv8 = 1'b1; or8 = (hold == 0);
    tick();
    acc = cyc;
    if (noise) begin a8 = ~a; b8 = ~b; bin8 = ~bin; end
    else iv8 = 1'b0;
    n = 0;
    while (ov8 !== 1'b1 && n < 50) begin tick(); n++; end
    chk({tag, "_latency"}, 64'(n), 64'd8);
    chk({tag, "_result"}, {55'd0, bout8, d8}, {55'd0, r});
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold"}, {53'd0, ov8, ir8, bout8, d8}, {53'd0, 1'b1, 1'b0, r});
    end
    iv8 = 1'b0; or8 = 1'b1;
    tick();
    chk({tag, "_release"}, {62'd0, ov8, ir8}, 64'd1);
  endtask

  task automatic op1(input logic a, input logic b, input logic bin, input string tag);
    logic [1:0] r;
    int n;
    r = {1'b0, a} - {1'b0, b} - {1'b0, bin};
    a1 = a; b1 = b; bin1 = bin; iv1 = 1'b1; or1 = 1'b1;
    tick();
    iv1 = 1'b0;
    n = 0;
    while (ov1 !== 1'b1 && n < 20) begin tick(); n++; end
    chk({tag, "_latency"}, 64'(n), 64'd1);
    chk({tag, "_result"}, {62'd0, bout1, d1}, {62'd0, r});
    tick();
    chk({tag, "_release"}, {62'd0, ov1, ir1}, 64'd1);
  endtask

  initial begin
    int acc;
    int prev;
    logic [7:0] ra, rb;
    logic rbin;

    rst_n = 1'b0;
    tick(); tick();
    chk("reset8", {53'd0, ir8, ov8, bout8, d8}, {53'd0, 1'b1, 1'b0, 1'b0, 8'h00});
    chk("reset1", {60'd0, ir1, ov1, bout1, d1}, {60'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    rst_n = 1'b1;
    tick();

    op8(8'h05, 8'h03, 1'b0, 0, 1'b0, "sub_5_3", acc);
    op8(8'h00, 8'h01, 1'b0, 0, 1'b0, "underflow", acc);
    op8(8'h80, 8'h80, 1'b1, 0, 1'b0, "borrow_in", acc);
    op8(8'h3C, 8'hC3, 1'b0, 5, 1'b1, "backpressure", acc);

    // Abandon an operation during its third SHIFT cycle.
    a8 = 8'h77; b8 = 8'h11; bin8 = 1'b1; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("midreset", {53'd0, ir8, ov8, bout8, d8}, {53'd0, 1'b1, 1'b0, 1'b0, 8'h00});
    rst_n = 1'b1;
    tick();
    op8(8'hA5, 8'h5A, 1'b0, 0, 1'b0, "after_reset", acc);

    for (int k = 0; k < 8; k++) begin
      logic [2:0] v;
      v = 3'(k);
      op1(v[2], v[1], v[0], $sformatf("w1_%0d", k));
    end

    prev = 0;
    for (int i = 0; i < 100; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rbin = 1'($urandom);
      op8(ra, rb, rbin, 0, 1'b0, "random", acc);
      if (i > 0) chk("spacing", 64'(acc - prev), 64'd10);
      prev = acc;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
